// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM state type and constants for the data-memory responder.
package mips_pkg;

    localparam int WORD_BYTES       = 4;
    localparam int DEFAULT_LATENCY  = 2;
    localparam int BYTE_OFFSET_BITS = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH_WORDS x 32 RAM with per-byte write enables
// and a registered read port. Contents are never reset.
module dmem_array
    import mips_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Read data only moves on a load access, so it stays put while a response is held.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    // Byte-lane writes plus the read-data register.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for a pipeline memory
// stage. One request outstanding at a time; the array is accessed on the edge
// that enters RESP so the response appears exactly LATENCY cycles after the
// handshake.
// Optional build macro DMEM_ERR_CHECK_EN: flags misaligned or out-of-range
// addresses with rsp_err; a faulting store is dropped, a faulting load returns 0.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_valid,
// rsp_rdata and rsp_err hold steady until that transfer.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output state_e      dbg_state
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam int         IDX_LO   = BYTE_OFFSET_BITS;
    localparam int         IDX_HI   = IDX_LO + AW - 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Word index wraps modulo DEPTH_WORDS by simply dropping the upper bits.
    logic [AW-1:0] req_idx;
    logic          req_fault;
    assign req_idx = req_addr[IDX_HI:IDX_LO];

`ifdef DMEM_ERR_CHECK_EN
    assign req_fault = (req_addr[IDX_LO-1:0] != '0) || (req_addr[31:IDX_HI+1] != '0);
`else
    logic unused_addr_bits;
    assign req_fault        = 1'b0;
    assign unused_addr_bits = ^{req_addr[31:IDX_HI+1], req_addr[IDX_LO-1:0]};
`endif

    state_e        state_d, state_q;
    logic [3:0]    cnt_d, cnt_q;
    logic          wr_d, wr_q;
    logic [AW-1:0] idx_d, idx_q;
    logic [31:0]   wdata_d, wdata_q;
    logic [3:0]    be_d, be_q;
    logic          fault_d, fault_q;
    logic          rsp_valid_d, rsp_valid_q;
    logic          rsp_err_d, rsp_err_q;
    logic          ld_ok_d, ld_ok_q;

    logic          handshake;
    logic          access;
    logic          use_live;
    logic          cur_wr;
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_be;
    logic          cur_fault;
    logic [31:0]   arr_rdata;

    assign req_ready = (state_q == IDLE) && reset;
    assign handshake = req_valid && req_ready;

    // With LATENCY=1 the access happens on the handshake edge itself, so the
    // live request fields feed the array; otherwise the captured copy does.
    assign use_live  = (state_q == IDLE);
    assign cur_wr    = use_live ? req_wr    : wr_q;
    assign cur_idx   = use_live ? req_idx   : idx_q;
    assign cur_wdata = use_live ? req_wdata : wdata_q;
    assign cur_be    = use_live ? req_be    : be_q;
    assign cur_fault = use_live ? req_fault : fault_q;

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        fault_d     = fault_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        ld_ok_d     = ld_ok_q;
        access      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    wr_d    = req_wr;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    fault_d = req_fault;
                    if (LATENCY == 1) begin
                        access = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Leave on the cycle the decremented count reaches zero.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    access = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    ld_ok_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (access) begin
            state_d     = RESP;
            cnt_d       = 4'd0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_fault;
            ld_ok_d     = !cur_wr && !cur_fault;
        end
    end

    // State and registered outputs; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            fault_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            fault_q     <= fault_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ld_ok_q     <= ld_ok_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (access && !cur_fault),
        .we   (cur_wr),
        .be   (cur_be),
        .addr (cur_idx),
        .wdata(cur_wdata),
        .rdata(arr_rdata)
    );

    // Load data is exposed only for a successful load; stores and faults read 0.
    assign rsp_rdata = ld_ok_q ? arr_rdata : 32'h0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against
// a word-array reference model. u_dut uses LATENCY=2, u_dut1 uses LATENCY=1.
module tb_dmem_responder;
    import mips_pkg::*;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;

    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;
    state_e      dbg_state;

    logic        req_valid1, req_ready1, req_wr1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
    logic [3:0]  req_be1;
    state_e      dbg_state1;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem[int];
    logic [31:0] ref1[int];
    logic [31:0] last_rdata;
    logic        last_err;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1), .dbg_state(dbg_state1)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rules
    function automatic bit m_err(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // One full request/response on u_dut, holding rsp_ready low for 'hold' cycles.
    task automatic txn(input string tag, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int          n;
        int          lat;
        int          idx;
        bit          fault;
        logic [31:0] held;
        fault = m_err(addr);
        idx   = m_idx(addr);
        if (wr || fault) exp_q.push_back(32'h0);
        else if (ref_mem.exists(idx)) exp_q.push_back(ref_mem[idx]);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_accept"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        chk({tag, "_err"}, 32'(rsp_err), 32'(fault));
        held       = rsp_rdata;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        if (exp_q.size() > 0) chk({tag, "_rdata"}, held, exp_q.pop_front());
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, held);
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
        chk({tag, "_ready_again"}, 32'(req_ready), 32'd1);
        if (wr && !fault) begin
            if (ref_mem.exists(idx)) ref_mem[idx] = m_merge(ref_mem[idx], wdata, be);
            else if (be == 4'hF) ref_mem[idx] = wdata;
        end
    endtask

    initial begin
        int          n;
        int          k;
        int          last_hs;
        int          cyc;
        bit          hs;
        bit          wr_l[6];
        logic [31:0] ad_l[6];
        logic [31:0] wd_l[6];
        logic [31:0] a;

        total = 0;
        bad   = 0;
        reset = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
        rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_wr1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0; req_be1 = 4'h0;
        rsp_ready1 = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_req_ready1", 32'(req_ready1), 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Store then load
        txn("st_deadbeef", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        chk("st_deadbeef_rdata_zero", last_rdata, 32'h0);
        txn("ld_deadbeef", 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("ld_deadbeef_value", last_rdata, 32'hDEADBEEF);

        // Byte-enabled merge
        txn("st_base", 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        txn("st_be0101", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        txn("ld_merge", 1'b0, 32'h20, 32'h0, 4'h0, 0);
        chk("ld_merge_value", last_rdata, 32'h11BB33DD);

        // be=0 store leaves memory alone but still responds
        txn("st_be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
        txn("ld_after_be0", 1'b0, 32'h20, 32'h0, 4'h0, 0);
        chk("ld_after_be0_value", last_rdata, 32'h11BB33DD);

        // Backpressure for 5 cycles
        txn("bp", 1'b0, 32'h10, 32'h0, 4'h0, 5);
        chk("bp_value", last_rdata, 32'hDEADBEEF);

        // Wrap-around of the word index
        txn("st_word0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0);
        txn("st_wrap", 1'b1, 32'h400, 32'hCAFE1234, 4'hF, 0);
        txn("ld_wrap", 1'b0, 32'h0, 32'h0, 4'h0, 0);
`ifdef DMEM_ERR_CHECK_EN
        chk("st_wrap_err_lit", 32'(last_err), 32'd0);
        chk("ld_wrap_value", last_rdata, 32'h0BADF00D);
        txn("ld_misaligned", 1'b0, 32'h12, 32'h0, 4'h0, 0);
        chk("ld_misaligned_err", 32'(last_err), 32'd1);
`else
        chk("ld_wrap_value", last_rdata, 32'hCAFE1234);
        txn("ld_misaligned", 1'b0, 32'h12, 32'h0, 4'h0, 0);
        chk("ld_misaligned_value", last_rdata, 32'hDEADBEEF);
`endif

        // Reset one cycle after a store handshake aborts the store
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10; req_wdata = 32'h55AA55AA; req_be = 4'hF;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("abort_accept", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata, 32'h0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(IDLE));
        step();
        step();
        chk("abort_held_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        step();
        txn("ld_after_abort", 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("ld_after_abort_value", last_rdata, 32'hDEADBEEF);

        // LATENCY=1 back-to-back with rsp_ready tied high
        for (int i = 0; i < 3; i++) begin
            wr_l[i]   = 1'b1;
            ad_l[i]   = 32'(4 * $urandom_range(0, DEPTH - 1));
            wd_l[i]   = $urandom;
            wr_l[i+3] = 1'b0;
            ad_l[i+3] = ad_l[i];
            wd_l[i+3] = 32'h0;
        end
        k = 0; last_hs = -1; cyc = 0;
        req_valid1 = 1'b1; req_wr1 = wr_l[0]; req_addr1 = ad_l[0]; req_wdata1 = wd_l[0]; req_be1 = 4'hF;
        while (k < 6 && cyc < 60) begin
            hs = req_ready1;
            step();
            cyc++;
            if (hs) begin
                if (last_hs >= 0) chk("l1_period", 32'(cyc - last_hs), 32'd2);
                last_hs = cyc;
                chk("l1_rsp_valid", 32'(rsp_valid1), 32'd1);
                chk("l1_err", 32'(rsp_err1), 32'd0);
                if (wr_l[k]) begin
                    ref1[m_idx(ad_l[k])] = wd_l[k];
                    chk("l1_store_rdata", rsp_rdata1, 32'h0);
                end else begin
                    chk("l1_load_rdata", rsp_rdata1, ref1[m_idx(ad_l[k])]);
                end
                k++;
                if (k < 6) begin
                    req_wr1 = wr_l[k]; req_addr1 = ad_l[k]; req_wdata1 = wd_l[k];
                end else begin
                    req_valid1 = 1'b0;
                end
            end
        end
        chk("l1_done", 32'(k), 32'd6);

        // Randomized traffic against the reference model
        for (int w = 0; w < 16; w++) begin
            txn("fill", 1'b1, 32'(4 * w), $urandom, 4'hF, 0);
        end
        for (int i = 0; i < 40; i++) begin
            a = 32'(1024 * (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0))
              + 32'(4 * $urandom_range(0, 15))
              + 32'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            txn("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
